// File: rtl/apb_req_arbiter.sv
`timescale 1ns/1ps
// apb_req_arbiter: round-robin arbiter that lets NUM_REQ requesters share a
// single APB master. The winning requester's fields drive the master's
// IN_* inputs. The arbiter watches the APB bus (PENABLE/PREADY/PSLVERR) to
// see when the transfer ends, and a transfer that stalls for TIMEOUT
// PENABLE cycles is aborted.
// Ports:
//   PCLK, PRESETn           clock, async active-low reset
//   REQ, REQ_*              per-requester request and packed fields (slice i = requester i)
//   GNT, DONE               one-hot grant, one-cycle completion pulse
//   RDATA, SLVERR, TOUT     result of the last completed or aborted transfer
//   Transfer, IN_*          command and fields for the APB master
//   PENABLE..PRDATA         bus monitor inputs
module apb_req_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STRB_WIDTH    = 4,
    parameter int TIMEOUT       = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic [NUM_REQ-1:0]               REQ,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_WDATA,
    input  logic [NUM_REQ-1:0]               REQ_WRITE,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    REQ_STRB,
    input  logic [NUM_REQ*3-1:0]             REQ_PROT,
    output logic [NUM_REQ-1:0]               GNT,
    output logic [NUM_REQ-1:0]               DONE,
    output logic [DATA_WIDTH-1:0]            RDATA,
    output logic                             SLVERR,
    output logic                             TOUT,
    output logic                             Transfer,
    output logic [ADDRESS_WIDTH-1:0]         IN_ADDR,
    output logic [DATA_WIDTH-1:0]            IN_DATA,
    output logic                             IN_WRITE,
    output logic [STRB_WIDTH-1:0]            IN_STRB,
    output logic [2:0]                       IN_PROT,
    input  logic                             PENABLE,
    input  logic                             PREADY,
    input  logic                             PSLVERR,
    input  logic [DATA_WIDTH-1:0]            PRDATA
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, BUSY, COMPLETE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   winner, last_winner, pick, cand;
    logic            found;
    logic [CW-1:0]   cnt;
    logic            busy, complete, expire;

    logic [ADDRESS_WIDTH-1:0] addr_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0]    wdata_a [NUM_REQ];
    logic [STRB_WIDTH-1:0]    strb_a  [NUM_REQ];
    logic [2:0]               prot_a  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = REQ_ADDR[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign wdata_a[g] = REQ_WDATA[g*DATA_WIDTH +: DATA_WIDTH];
        assign strb_a[g]  = REQ_STRB[g*STRB_WIDTH +: STRB_WIDTH];
        assign prot_a[g]  = REQ_PROT[g*3 +: 3];
    end

    assign busy     = (state == BUSY);
    assign complete = busy & PENABLE & (PREADY | PSLVERR);
    // a stall is only declared on a PENABLE cycle that did not complete
    assign expire   = busy & PENABLE & ~complete
                    & (cnt == CW'(TIMEOUT - 1));

    // round-robin: scan upward starting just after the last winner
    always_comb begin
        pick  = last_winner;
        cand  = last_winner;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_winner) + k) % NUM_REQ);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (found) state_nxt = BUSY;
            BUSY:     if (complete || expire) state_nxt = COMPLETE;
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Transfer falls in the ending cycle so the master does not start
    // another SETUP phase back-to-back
    always_comb begin
        Transfer = busy & ~complete & ~expire;
        IN_ADDR  = '0;
        IN_DATA  = '0;
        IN_WRITE = 1'b0;
        IN_STRB  = '0;
        IN_PROT  = '0;
        if (busy) begin
            IN_ADDR  = addr_a[winner];
            IN_DATA  = wdata_a[winner];
            IN_WRITE = REQ_WRITE[winner];
            IN_STRB  = strb_a[winner];
            IN_PROT  = prot_a[winner];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            winner      <= '0;
            last_winner <= IW'(NUM_REQ - 1);
            cnt         <= '0;
            GNT         <= '0;
            DONE        <= '0;
            RDATA       <= '0;
            SLVERR      <= 1'b0;
            TOUT        <= 1'b0;
        end else begin
            DONE <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        winner <= pick;
                        GNT    <= ONE << pick;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (complete) begin
                        GNT    <= '0;
                        DONE   <= ONE << winner;
                        if (!REQ_WRITE[winner]) RDATA <= PRDATA;
                        SLVERR <= PSLVERR;
                        TOUT   <= 1'b0;
                    end else if (expire) begin
                        GNT    <= '0;
                        DONE   <= ONE << winner;
                        RDATA  <= '0;
                        SLVERR <= 1'b1;
                        TOUT   <= 1'b1;
                    end else if (PENABLE) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                COMPLETE: last_winner <= winner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
`timescale 1ns/1ps
// tb_apb_req_arbiter: directed bench with a small APB master/slave model
// and a transfer-level reference model compared on every falling edge.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req;
    logic [AW-1:0]   f_addr  [N];
    logic [DW-1:0]   f_wdata [N];
    logic [N-1:0]    f_write;
    logic [SW-1:0]   f_strb  [N];
    logic [2:0]      f_prot  [N];
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_strb;
    logic [N*3-1:0]  req_prot;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = f_addr[i];
            req_wdata[i*DW +: DW] = f_wdata[i];
            req_strb[i*SW +: SW]  = f_strb[i];
            req_prot[i*3 +: 3]    = f_prot[i];
        end
    end

    logic [N-1:0]  gnt, done;
    logic [DW-1:0] rdata, in_data, prdata;
    logic [AW-1:0] in_addr;
    logic [SW-1:0] in_strb;
    logic [2:0]    in_prot;
    logic          slverr, tout, transfer, in_write;
    logic          penable, pready, pslverr;

    apb_req_arbiter #(
        .NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .STRB_WIDTH(SW), .TIMEOUT(TO)
    ) dut (
        .PCLK(clk), .PRESETn(rst_n),
        .REQ(req), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .REQ_WRITE(f_write), .REQ_STRB(req_strb), .REQ_PROT(req_prot),
        .GNT(gnt), .DONE(done), .RDATA(rdata),
        .SLVERR(slverr), .TOUT(tout), .Transfer(transfer),
        .IN_ADDR(in_addr), .IN_DATA(in_data), .IN_WRITE(in_write),
        .IN_STRB(in_strb), .IN_PROT(in_prot),
        .PENABLE(penable), .PREADY(pready), .PSLVERR(pslverr),
        .PRDATA(prdata)
    );

    // APB master: IDLE -> SETUP -> ACCESS, leaves ACCESS once Transfer falls
    int m_st;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_st <= 0;
        else case (m_st)
            0: if (transfer) m_st <= 1;
            1: m_st <= 2;
            default: if (!transfer) m_st <= 0;
        endcase
    end
    assign penable = (m_st == 2);

    // APB slave: wait_n stall cycles, error mode, or hang forever
    int acc_cnt;
    int wait_n;
    bit hang, err_mode;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt <= 0;
        else        acc_cnt <= penable ? acc_cnt + 1 : 0;
    end
    assign pready  = penable && !hang && !err_mode && (acc_cnt >= wait_n);
    assign pslverr = penable && err_mode;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int rr(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // reference model, one transfer at a time
    int            m_phase = 0;
    int            m_win = 0;
    int            m_last = N - 1;
    int            m_pen = 0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_slverr = 1'b0;
    logic          m_tout = 1'b0;
    logic [N-1:0]  exp_oh;
    logic [N-1:0]  prev_gnt = '0;
    bit            outcome;
    int            gidx;
    int            glog[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_done", done, 0);
            chk("rst_xfer", transfer, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_slverr", slverr, 0);
            chk("rst_tout", tout, 0);
            chk("rst_in_addr", in_addr, 0);
            m_phase  = 0;
            m_last   = N - 1;
            m_rdata  = '0;
            m_slverr = 1'b0;
            m_tout   = 1'b0;
            prev_gnt = '0;
        end else begin
            chk("gnt_onehot0", $countones(gnt) <= 1, 1);
            chk("done_onehot0", $countones(done) <= 1, 1);
            chk("gnt_done_excl", (gnt != 0) && (done != 0), 0);
            chk("rdata", rdata, m_rdata);
            chk("slverr", slverr, m_slverr);
            chk("tout", tout, m_tout);
            if (gnt != 0 && prev_gnt == 0) begin
                gidx = -1;
                for (int i = 0; i < N; i++) if (gnt[i]) gidx = i;
                glog.push_back(gidx);
            end
            prev_gnt = gnt;
            exp_oh = '0;
            if (m_win >= 0) exp_oh[m_win] = 1'b1;
            case (m_phase)
                0: begin
                    chk("idle_gnt", gnt, 0);
                    chk("idle_done", done, 0);
                    chk("idle_xfer", transfer, 0);
                    if (req != 0) begin
                        m_win   = rr(req, m_last);
                        m_pen   = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    chk("gnt", gnt, exp_oh);
                    chk("in_addr", in_addr, f_addr[m_win]);
                    chk("in_data", in_data, f_wdata[m_win]);
                    chk("in_write", in_write, f_write[m_win]);
                    chk("in_strb", in_strb, f_strb[m_win]);
                    chk("in_prot", in_prot, f_prot[m_win]);
                    outcome = 1'b0;
                    if (penable) begin
                        m_pen++;
                        if (pready || pslverr) begin
                            outcome = 1'b1;
                            if (!f_write[m_win]) m_rdata = prdata;
                            m_slverr = pslverr;
                            m_tout   = 1'b0;
                        end else if (m_pen == TO) begin
                            outcome  = 1'b1;
                            m_rdata  = '0;
                            m_slverr = 1'b1;
                            m_tout   = 1'b1;
                        end
                    end
                    chk("xfer", transfer, !outcome);
                    if (outcome) m_phase = 2;
                end
                default: begin
                    chk("done", done, exp_oh);
                    chk("done_gnt", gnt, 0);
                    chk("done_xfer", transfer, 0);
                    m_last  = m_win;
                    m_phase = 0;
                end
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (done != 0) return;
        end
        chk("wait_done_bound", 0, 1);
    endtask

    int dcnt;
    int pens;

    initial begin
        req = '0;
        f_write = '0;
        for (int i = 0; i < N; i++) begin
            f_addr[i]  = 32'h4000_0000 + 32'(i * 16);
            f_wdata[i] = 32'hA0A0_0000 + 32'(i);
            f_strb[i]  = 4'hF - 4'(i);
            f_prot[i]  = 3'(i + 1);
        end
        wait_n = 0; hang = 0; err_mode = 0; prdata = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("t0_gnt", gnt, 0);
        chk("t0_rdata", rdata, 0);

        // single read, cycle-exact latency
        prdata = 32'hCAFE_0001;
        req = 4'b0001;
        tick();
        chk("t1_gnt_c1", gnt, 4'b0001);
        chk("t1_xfer_c1", transfer, 1);
        tick();
        chk("t1_xfer_c2", transfer, 1);
        tick();
        chk("t1_xfer_c3", transfer, 0);
        tick();
        chk("t1_done_c4", done, 4'b0001);
        chk("t1_rdata", rdata, 32'hCAFE_0001);
        chk("t1_slverr", slverr, 0);
        req = '0;
        tick(); tick();

        // contention, all held, reset gives requester 0 first
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        glog.delete();
        prdata = 32'h5555_0000;
        req = 4'b1111;
        dcnt = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (done != 0) dcnt++;
            if (dcnt == 5) break;
        end
        req = '0;
        chk("t2_dones", dcnt, 5);
        chk("t2_grants", glog.size(), 5);
        chk("t2_g0", glog[0], 0);
        chk("t2_g1", glog[1], 1);
        chk("t2_g2", glog[2], 2);
        chk("t2_g3", glog[3], 3);
        chk("t2_g4", glog[4], 0);
        tick(); tick();

        // write with 3 wait states
        f_write[1] = 1'b1;
        f_wdata[1] = 32'h1234_5678;
        wait_n = 3;
        req = 4'b0010;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("t3_in_data", in_data, 32'h1234_5678);
            chk("t3_no_done", done, 0);
        end
        tick();
        chk("t3_done_c7", done, 4'b0010);
        chk("t3_rdata_kept", rdata, 32'h5555_0000);
        req = '0;
        wait_n = 0;
        tick(); tick();

        // slave error without PREADY
        err_mode = 1;
        prdata = 32'hDEAD_0002;
        req = 4'b0100;
        tick(); tick(); tick();
        chk("t4_xfer_drop", transfer, 0);
        tick();
        chk("t4_done", done, 4'b0100);
        chk("t4_slverr", slverr, 1);
        chk("t4_tout", tout, 0);
        req = '0;
        err_mode = 0;
        tick(); tick();

        // timeout on requester 3, then requester 0 is served
        f_write[3] = 1'b1;
        hang = 1;
        prdata = 32'h0BAD_0000;
        req = 4'b1001;
        pens = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (penable) pens++;
            if (done != 0) break;
        end
        hang = 0;
        req = 4'b0001;
        chk("t5_done", done, 4'b1000);
        chk("t5_pen_cycles", pens, 16);
        chk("t5_slverr", slverr, 1);
        chk("t5_tout", tout, 1);
        chk("t5_rdata", rdata, 0);
        wait_done();
        chk("t5_next_done", done, 4'b0001);
        chk("t5_next_tout", tout, 0);
        chk("t5_next_rdata", rdata, 32'h0BAD_0000);
        req = '0;
        tick(); tick();

        // reset during requester 2 transfer
        hang = 1;
        req = 4'b0100;
        tick();
        chk("t6_gnt2", gnt, 4'b0100);
        req = 4'b0110;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_xfer", transfer, 0);
        chk("t6_rst_slverr", slverr, 0);
        chk("t6_rst_tout", tout, 0);
        tick();
        chk("t6_rst_no_done", done, 0);
        rst_n = 1'b1;
        hang = 0;
        tick();
        chk("t6_first_gnt", gnt, 4'b0010);
        req = 4'b0100;
        wait_done();
        chk("t6_drop_done", done, 4'b0010);
        wait_done();
        chk("t6_next_done", done, 4'b0100);
        req = '0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
